// File: rtl/vec_pkg.sv
// rtl/vec_pkg.sv - shared widths, opcodes and FSM encoding for the vector memory unit
package vec_pkg;

  localparam int ELEM_W   = 16;
  localparam int NUM_ELEM = 16;
  localparam int VEC_W    = ELEM_W * NUM_ELEM;
  localparam int ADDR_W   = 16;
  localparam int SEL_W    = $clog2(NUM_ELEM);
  localparam int CNT_W    = SEL_W + 1;

  localparam logic [3:0] VLD = 4'b0100;
  localparam logic [3:0] VST = 4'b0101;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

endpackage

// File: rtl/vec_elem_sel.sv
// rtl/vec_elem_sel.sv - combinational 16:1 element picker feeding mem_wdata
module vec_elem_sel
  import vec_pkg::*;
(
  input  logic [VEC_W-1:0]  vec_i,
  input  logic [SEL_W-1:0]  sel_i,
  output logic [ELEM_W-1:0] elem_o
);

  always_comb begin
    elem_o = '0;
    for (int i = 0; i < NUM_ELEM; i++) begin
      if (sel_i == SEL_W'(i)) elem_o = vec_i[i*ELEM_W +: ELEM_W];
    end
  end

endmodule

// File: rtl/vec_mem_unit.sv
// rtl/vec_mem_unit.sv - moves a 256-bit vector to/from 16-bit data memory, one element per grant
module vec_mem_unit
  import vec_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              is_store,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [VEC_W-1:0]  st_data,
  output logic              busy,
  output logic              done,
  output logic [VEC_W-1:0]  ld_data,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [ELEM_W-1:0] mem_wdata,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [ELEM_W-1:0] mem_rdata
);

  logic [1:0]        state_q, state_d;
  logic              is_store_q, is_store_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [VEC_W-1:0]  st_data_q, st_data_d;
  logic [VEC_W-1:0]  ld_data_q, ld_data_d;
  logic [CNT_W-1:0]  issue_cnt_q, issue_cnt_d;
  logic [CNT_W-1:0]  resp_cnt_q, resp_cnt_d;
  logic [ELEM_W-1:0] st_elem;
  logic              issuing, grant, resp_take, last_grant, last_resp;

  assign issuing    = (state_q == ST_ISSUE);
  assign grant      = issuing && mem_gnt;
  // Responses only count for loads in flight and never past the last element.
  assign resp_take  = mem_rvalid && !is_store_q
                      && (issuing || state_q == ST_DRAIN)
                      && (resp_cnt_q < CNT_W'(NUM_ELEM));
  assign last_grant = grant && (issue_cnt_q == CNT_W'(NUM_ELEM - 1));
  assign last_resp  = resp_take && (resp_cnt_q == CNT_W'(NUM_ELEM - 1));

  vec_elem_sel u_elem_sel (
    .vec_i  (st_data_q),
    .sel_i  (issue_cnt_q[SEL_W-1:0]),
    .elem_o (st_elem)
  );

  always_comb begin
    state_d     = state_q;
    is_store_d  = is_store_q;
    base_d      = base_q;
    st_data_d   = st_data_q;
    ld_data_d   = ld_data_q;
    issue_cnt_d = issue_cnt_q;
    resp_cnt_d  = resp_cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          is_store_d  = is_store;
          base_d      = base_addr;
          st_data_d   = st_data;
          issue_cnt_d = '0;
          resp_cnt_d  = '0;
          if (!is_store) ld_data_d = '0;
          state_d     = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (last_grant) state_d = is_store_q ? ST_DONE : ST_DRAIN;
      end
      ST_DRAIN: begin
        if (last_resp) state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (grant) issue_cnt_d = issue_cnt_q + CNT_W'(1);
    if (resp_take) begin
      ld_data_d[resp_cnt_q[SEL_W-1:0]*ELEM_W +: ELEM_W] = mem_rdata;
      resp_cnt_d = resp_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      is_store_q  <= 1'b0;
      base_q      <= '0;
      st_data_q   <= '0;
      ld_data_q   <= '0;
      issue_cnt_q <= '0;
      resp_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      is_store_q  <= is_store_d;
      base_q      <= base_d;
      st_data_q   <= st_data_d;
      ld_data_q   <= ld_data_d;
      issue_cnt_q <= issue_cnt_d;
      resp_cnt_q  <= resp_cnt_d;
    end
  end

  // Outputs decode straight from state so an async reset drops mem_req at once.
  assign busy      = issuing || (state_q == ST_DRAIN);
  assign done      = (state_q == ST_DONE);
  assign ld_data   = ld_data_q;
  assign mem_req   = issuing;
  assign mem_we    = issuing && is_store_q;
  assign mem_addr  = issuing ? (base_q + ADDR_W'(issue_cnt_q)) : '0;
  assign mem_wdata = (issuing && is_store_q) ? st_elem : '0;

endmodule

// File: tb/tb_vec_mem_unit.sv
// tb/tb_vec_mem_unit.sv - self-checking bench for vec_mem_unit against a memory model
module tb_vec_mem_unit;
  import vec_pkg::*;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic              is_store = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic [VEC_W-1:0]  st_data = '0;
  logic              busy, done;
  logic [VEC_W-1:0]  ld_data;
  logic              mem_req, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [ELEM_W-1:0] mem_wdata;
  logic              mem_gnt = 1'b0;
  logic              mem_rvalid = 1'b0;
  logic [ELEM_W-1:0] mem_rdata = '0;

  vec_mem_unit dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .is_store   (is_store),
    .base_addr  (base_addr),
    .st_data    (st_data),
    .busy       (busy),
    .done       (done),
    .ld_data    (ld_data),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_gnt    (mem_gnt),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;
  logic [VEC_W-1:0] model_ld = '0;

  // Memory contents; unseen words get random data on first touch.
  logic [ELEM_W-1:0] mem_words [int];
  function automatic logic [ELEM_W-1:0] mem_rd(input int a);
    if (!mem_words.exists(a)) mem_words[a] = ELEM_W'($urandom);
    return mem_words[a];
  endfunction

  function automatic logic [VEC_W-1:0] rand_vec();
    logic [VEC_W-1:0] v;
    for (int j = 0; j < VEC_W/32; j++) v[j*32 +: 32] = $urandom;
    return v;
  endfunction

  int gnt_mode = 0;
  int rd_lat = 1;
  bit spur_en = 0;
  int resp_due[$];
  logic [ELEM_W-1:0] resp_dat[$];
  logic [ADDR_W-1:0] hs_addr[$];
  logic              hs_we[$];
  logic [ELEM_W-1:0] hs_wdata[$];
  int hs_cnt, req_cycles, done_cnt, done_cyc, busy_cnt, busy_first, hold_viol;
  int last_resp_cyc, last_hs_cyc;
  logic              prev_stall = 1'b0;
  logic [ADDR_W-1:0] prev_addr;
  logic              prev_we;
  logic [ELEM_W-1:0] prev_wdata;

  // Memory side: grants, in-order read responses, and bus observation.
  always @(negedge clk) begin
    if (rst) begin
      resp_due.delete();
      resp_dat.delete();
      mem_gnt    = 1'b0;
      mem_rvalid = 1'b0;
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && !(mem_req && mem_addr == prev_addr && mem_we == prev_we
                          && mem_wdata == prev_wdata)) hold_viol++;
      mem_rvalid = 1'b0;
      mem_rdata  = '0;
      if (resp_due.size() > 0 && resp_due[0] == cyc) begin
        mem_rvalid = 1'b1;
        mem_rdata  = resp_dat.pop_front();
        void'(resp_due.pop_front());
        last_resp_cyc = cyc;
      end else if (spur_en) begin
        mem_rvalid = 1'b1;
        mem_rdata  = ELEM_W'($urandom);
      end
      case (gnt_mode)
        0:       mem_gnt = 1'b1;
        1:       mem_gnt = cyc[0];
        default: mem_gnt = 1'($urandom_range(0, 1));
      endcase
      if (mem_req) req_cycles++;
      if (mem_req && mem_gnt) begin
        hs_cnt++;
        last_hs_cyc = cyc;
        hs_addr.push_back(mem_addr);
        hs_we.push_back(mem_we);
        hs_wdata.push_back(mem_wdata);
        if (mem_we) mem_words[int'(mem_addr)] = mem_wdata;
        else begin
          resp_due.push_back(cyc + rd_lat);
          resp_dat.push_back(mem_rd(int'(mem_addr)));
        end
      end
      prev_stall = mem_req && !mem_gnt;
      prev_addr  = mem_addr;
      prev_we    = mem_we;
      prev_wdata = mem_wdata;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (busy) begin
        if (busy_cnt == 0) busy_first = cyc;
        busy_cnt++;
      end
    end
  end

  task automatic chk(input string tag, input logic [VEC_W-1:0] obs, input logic [VEC_W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_obs();
    hs_addr.delete();
    hs_we.delete();
    hs_wdata.delete();
    hs_cnt = 0; req_cycles = 0; done_cnt = 0; done_cyc = -1;
    busy_cnt = 0; busy_first = -1; hold_viol = 0;
    last_resp_cyc = -1; last_hs_cyc = -1;
  endtask

  // One full transfer; exp_lat > 0 also checks exact cycle timing.
  task automatic run_xfer(input string tag, input bit st, input logic [ADDR_W-1:0] base,
                          input logic [VEC_W-1:0] sv, input int exp_lat, input bit poke);
    logic [VEC_W-1:0]  exp_ld;
    logic [ADDR_W-1:0] a;
    int start_cyc;
    exp_ld = '0;
    if (!st) begin
      for (int i = 0; i < NUM_ELEM; i++) begin
        a = base + ADDR_W'(i);
        exp_ld[i*ELEM_W +: ELEM_W] = mem_rd(int'(a));
      end
    end
    @(negedge clk);
    clear_obs();
    start = 1'b1; is_store = st; base_addr = base; st_data = sv;
    start_cyc = cyc;
    @(negedge clk);
    start = 1'b0; is_store = ~st; base_addr = ADDR_W'($urandom); st_data = rand_vec();
    for (int i = 0; i < 2000 && done_cnt == 0; i++) begin
      @(negedge clk);
      start = (poke && i == 5);
    end
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk({tag, ":done_pulses"}, done_cnt, 1);
    chk({tag, ":grants"}, hs_cnt, NUM_ELEM);
    for (int i = 0; i < NUM_ELEM; i++) begin
      a = base + ADDR_W'(i);
      chk($sformatf("%s:req%0d", tag, i),
          {hs_addr[i], hs_we[i], st ? hs_wdata[i] : 16'h0},
          {a, st, st ? sv[i*ELEM_W +: ELEM_W] : 16'h0});
    end
    chk({tag, ":hold_stable"}, hold_viol, 0);
    if (!st) model_ld = exp_ld;
    chk({tag, ":ld_data"}, ld_data, model_ld);
    if (st) chk({tag, ":done_after_last_grant"}, done_cyc, last_hs_cyc + 1);
    else    chk({tag, ":done_after_last_rvalid"}, done_cyc, last_resp_cyc + 1);
    if (exp_lat > 0) begin
      chk({tag, ":latency"}, done_cyc - start_cyc, exp_lat);
      chk({tag, ":busy_first"}, busy_first, start_cyc + 1);
      chk({tag, ":busy_cycles"}, busy_cnt, exp_lat - 1);
      chk({tag, ":req_cycles"}, req_cycles, NUM_ELEM);
    end
  endtask

  logic [VEC_W-1:0]  sv;
  logic [ADDR_W-1:0] b;

  initial begin
    repeat (3) @(negedge clk);
    chk("reset:outs", {busy, done, mem_req, mem_we, mem_addr, mem_wdata}, '0);
    chk("reset:ld_data", ld_data, '0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < NUM_ELEM; i++) mem_words[16'h0100 + i] = ELEM_W'(16'hA000 + i);
    run_xfer("load", 1'b0, 16'h0100, '0, 18, 1'b0);

    for (int i = 0; i < NUM_ELEM; i++) sv[i*ELEM_W +: ELEM_W] = ELEM_W'(16'h1111 * i);
    spur_en = 1;
    run_xfer("store", 1'b1, 16'h0200, sv, 17, 1'b0);
    spur_en = 0;

    run_xfer("wrap", 1'b0, 16'hFFFC, '0, 18, 1'b0);

    gnt_mode = 1; rd_lat = 3;
    run_xfer("bp_load", 1'b0, ADDR_W'($urandom), '0, 0, 1'b0);
    run_xfer("bp_store", 1'b1, ADDR_W'($urandom), rand_vec(), 0, 1'b0);
    gnt_mode = 0; rd_lat = 1;

    run_xfer("poke_load", 1'b0, ADDR_W'($urandom), '0, 18, 1'b1);
    run_xfer("poke_store", 1'b1, ADDR_W'($urandom), rand_vec(), 17, 1'b1);
    @(negedge clk);
    clear_obs();
    spur_en = 1;
    repeat (12) @(negedge clk);
    spur_en = 0;
    @(negedge clk);
    chk("idle:req_cycles", req_cycles, 0);
    chk("idle:busy_cycles", busy_cnt, 0);
    chk("idle:ld_data", ld_data, model_ld);

    @(negedge clk);
    clear_obs();
    start = 1'b1; is_store = 1'b0; base_addr = ADDR_W'($urandom);
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 100 && hs_cnt < 5; i++) @(negedge clk);
    chk("rst:req_before", mem_req, 1'b1);
    rst = 1'b1;
    #1;
    chk("rst:mem_req", mem_req, 1'b0);
    chk("rst:busy_done", {busy, done}, 2'b00);
    chk("rst:ld_data", ld_data, '0);
    model_ld = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst:no_done", done_cnt, 0);
    chk("rst:idle", busy, 1'b0);
    run_xfer("after_rst", 1'b0, ADDR_W'($urandom), '0, 18, 1'b0);

    for (int k = 0; k < 5; k++) begin
      gnt_mode = 2;
      rd_lat = $urandom_range(1, 4);
      b = ADDR_W'($urandom);
      run_xfer($sformatf("rnd_st%0d", k), 1'b1, b, rand_vec(), 0, 1'b0);
      rd_lat = $urandom_range(1, 4);
      run_xfer($sformatf("rnd_ld%0d", k), 1'b0, b + ADDR_W'($urandom_range(0, 8)), '0, 0, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
